pipelined_addsub: RTL and testbench

- Parametrised, pipelined, multi-word adder/subtractor. It is the successor to the team's fixed 4-bit combinational ripple adder.
- Operand width is split into CHUNK-bit slices. Each pipeline stage adds one slice and registers the carry into the next stage.
- Adds subtract mode, status flags (carry, signed overflow, zero) and a valid/ready streaming handshake.
- Sits between operand source FIFOs and the result writeback path of the datapath.

---
 rtl/pipelined_addsub_if.sv | 28 ++
 rtl/pipelined_addsub.sv | 101 ++++++++++
 tb/tb_pipelined_addsub.sv | 250 +++++++++++++++++++++++++
 3 files changed

// File: rtl/pipelined_addsub_if.sv
// Streaming operand/result bundle for pipelined_addsub.
// The master drives the operands and out_ready, and the slave (the adder) drives the results.
interface pipelined_addsub_if #(
    parameter int WIDTH = 16
) ();
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             cin;
    logic             sub;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] s;
    logic             cout;
    logic             ovf;
    logic             zero;

    modport master (
        output in_valid, a, b, cin, sub, out_ready,
        input  in_ready, out_valid, s, cout, ovf, zero
    );

    modport slave (
        input  in_valid, a, b, cin, sub, out_ready,
        output in_ready, out_valid, s, cout, ovf, zero
    );
endinterface

// File: rtl/pipelined_addsub.sv
// Pipelined multi-word adder/subtractor: one CHUNK-bit slice per stage, with the carry registered between stages.
// A single advance enable stalls the whole pipe, so bubbles are not compressed.
module pipelined_addsub #(
    parameter int WIDTH = 16,
    parameter int CHUNK = 4
) (
    input  logic                clk,
    input  logic                rst_n,
    pipelined_addsub_if.slave   bus
);
    localparam int STAGES = WIDTH / CHUNK;

    logic             adv;
    logic [WIDTH-1:0] b_eff;
    logic             c0;

    assign adv          = bus.out_ready | ~bus.out_valid;
    assign bus.in_ready = adv;
    assign b_eff        = bus.sub ? ~bus.b : bus.b;
    assign c0           = bus.sub ? ~bus.cin : bus.cin;

    for (genvar k = 0; k < STAGES; k++) begin : stg
        localparam int RIN = WIDTH - k * CHUNK;
        localparam int D   = (k + 1) * CHUNK;

        logic [RIN-1:0]   a_src;
        logic [RIN-1:0]   b_src;
        logic             c_in;
        logic             v_in;
        logic [CHUNK:0]   sum;
        logic [D-1:0]     s_nxt;
        logic             v_q;
        logic             c_q;
        logic [D-1:0]     s_q;

        if (k == 0) begin : src
            assign a_src = bus.a;
            assign b_src = b_eff;
            assign c_in  = c0;
            assign v_in  = bus.in_valid;
            assign s_nxt = sum[CHUNK-1:0];
        end else begin : src
            assign a_src = stg[k-1].rem.a_q;
            assign b_src = stg[k-1].rem.b_q;
            assign c_in  = stg[k-1].c_q;
            assign v_in  = stg[k-1].v_q;
            assign s_nxt = {sum[CHUNK-1:0], stg[k-1].s_q};
        end

        assign sum = {1'b0, a_src[CHUNK-1:0]} + {1'b0, b_src[CHUNK-1:0]}
                   + {{CHUNK{1'b0}}, c_in};

        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                v_q <= 1'b0;
                c_q <= 1'b0;
                s_q <= '0;
            end else if (adv) begin
                v_q <= v_in;
                c_q <= sum[CHUNK];
                s_q <= s_nxt;
            end
        end

        if (k < STAGES - 1) begin : rem
            // Operand slices not yet added ride along with the beat.
            logic [RIN-CHUNK-1:0] a_q;
            logic [RIN-CHUNK-1:0] b_q;

            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    a_q <= '0;
                    b_q <= '0;
                end else if (adv) begin
                    a_q <= a_src[RIN-1:CHUNK];
                    b_q <= b_src[RIN-1:CHUNK];
                end
            end
        end else begin : fin
            logic ovf_q;
            logic zero_q;

            // The carry into the MSB is recovered as a ^ b ^ s at that bit.
            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    ovf_q  <= 1'b0;
                    zero_q <= 1'b0;
                end else if (adv) begin
                    ovf_q  <= a_src[CHUNK-1] ^ b_src[CHUNK-1] ^ sum[CHUNK-1] ^ sum[CHUNK];
                    zero_q <= (s_nxt == '0);
                end
            end
        end
    end

    assign bus.out_valid = stg[STAGES-1].v_q;
    assign bus.s         = stg[STAGES-1].s_q;
    assign bus.cout      = stg[STAGES-1].c_q;
    assign bus.ovf       = stg[STAGES-1].fin.ovf_q;
    assign bus.zero      = stg[STAGES-1].fin.zero_q;
endmodule

// File: tb/tb_pipelined_addsub.sv
// Scoreboard bench for pipelined_addsub: the driver pushes expectations, and an output monitor pops and compares them.
// The reference model uses plain integer arithmetic. Two extra instances cover CHUNK=WIDTH and the 32/8 configuration.
module tb_pipelined_addsub;
    logic clk = 1'b0;
    logic rst_n;
    int   cyc = 0;
    int   checks = 0;
    int   errors = 0;
    int   waits = 0;
    int   nout = 0;
    bit   lat_on = 1'b1;

    typedef struct {
        logic [15:0] s;
        logic        cout;
        logic        ovf;
        logic        zero;
        int          acc;
        bit          lat;
    } exp_t;

    exp_t sb[$];

    pipelined_addsub_if #(.WIDTH(16)) bus ();
    pipelined_addsub_if #(.WIDTH(16)) bus1 ();
    pipelined_addsub_if #(.WIDTH(32)) bus32 ();

    pipelined_addsub #(.WIDTH(16), .CHUNK(4))  dut   (.clk(clk), .rst_n(rst_n), .bus(bus));
    pipelined_addsub #(.WIDTH(16), .CHUNK(16)) dut1  (.clk(clk), .rst_n(rst_n), .bus(bus1));
    pipelined_addsub #(.WIDTH(32), .CHUNK(8))  dut32 (.clk(clk), .rst_n(rst_n), .bus(bus32));

    always #5 clk = ~clk;
    always @(posedge clk) cyc = cyc + 1;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic exp_t mk(input logic [15:0] s, input logic cout, ovf, zero);
        exp_t e;
        e.s = s; e.cout = cout; e.ovf = ovf; e.zero = zero; e.acc = 0; e.lat = 1'b0;
        return e;
    endfunction

    // Reference: unsigned result gives s/cout, signed result range gives ovf.
    function automatic exp_t model(input logic [15:0] a, b, input logic cin, sub);
        exp_t e;
        int ua, ub, sa, sb_, ci, r, rs;
        ua = int'(a); ub = int'(b);
        sa = int'($signed(a)); sb_ = int'($signed(b));
        ci = cin ? 1 : 0;
        if (!sub) begin
            r = ua + ub + ci; rs = sa + sb_ + ci; e.cout = (r > 65535);
        end else begin
            r = ua - ub - ci; rs = sa - sb_ - ci; e.cout = (r >= 0);
        end
        e.s    = r[15:0];
        e.ovf  = (rs > 32767) || (rs < -32768);
        e.zero = (e.s == 16'h0);
        e.acc  = 0; e.lat = 1'b0;
        return e;
    endfunction

    // Called at posedge+1; returns at posedge+1 after the accepting edge.
    task automatic send(input logic [15:0] ta, tb_, input logic tcin, tsub, input exp_t e);
        int n = 0;
        bit ok = 1'b0;
        bus.a = ta; bus.b = tb_; bus.cin = tcin; bus.sub = tsub; bus.in_valid = 1'b1;
        forever begin
            @(negedge clk);
            if (bus.in_ready) begin ok = 1'b1; break; end
            n++; waits++;
            if (n > 50) break;
            @(posedge clk); #1;
        end
        if (ok) begin
            e.acc = cyc + 1; e.lat = lat_on;
            sb.push_back(e);
            @(posedge clk); #1;
        end else begin
            checks++; errors++;
            $display("FAIL send_timeout: got in_ready low for %0d cycles expected acceptance", n);
            bus.in_valid = 1'b0;
        end
    endtask

    task automatic idle();
        bus.in_valid = 1'b0;
    endtask

    task automatic drain(input string name);
        int n = 0;
        while (sb.size() != 0 && n < 100) begin
            @(posedge clk); #1; n++;
        end
        if (sb.size() != 0) begin
            checks++; errors++;
            $display("FAIL %s_drain: got %0d beats pending expected 0", name, sb.size());
            sb.delete();
        end
    endtask

    task automatic chk_reset(input string tag);
        chk({tag, "_out_valid"}, 64'(bus.out_valid), 64'h0);
        chk({tag, "_in_ready"},  64'(bus.in_ready),  64'h1);
        chk({tag, "_s"},         64'(bus.s),         64'h0);
        chk({tag, "_cout"},      64'(bus.cout),      64'h0);
        chk({tag, "_ovf"},       64'(bus.ovf),       64'h0);
        chk({tag, "_zero"},      64'(bus.zero),      64'h0);
    endtask

    // Output monitor: decoupled from the driver.
    always @(negedge clk) begin
        if (rst_n && bus.out_valid) begin
            if (bus.out_ready) begin
                if (sb.size() == 0) begin
                    checks++; errors++;
                    $display("FAIL unexpected_beat: got s=%0h with empty scoreboard expected no beat", bus.s);
                end else begin
                    exp_t e;
                    e = sb.pop_front();
                    chk($sformatf("beat%0d_s_cout_ovf_zero", nout),
                        64'({bus.s, bus.cout, bus.ovf, bus.zero}),
                        64'({e.s, e.cout, e.ovf, e.zero}));
                    if (e.lat) chk($sformatf("beat%0d_latency", nout), 64'(cyc + 1 - e.acc), 64'd4);
                    nout++;
                end
            end else begin
                chk("stall_in_ready", 64'(bus.in_ready), 64'h0);
                if (sb.size() != 0) chk("stall_hold_s", 64'(bus.s), 64'(sb[0].s));
            end
        end
    end

    initial begin
        int stale;
        int n;
        rst_n = 1'b0;
        bus.in_valid = 0; bus.a = 0; bus.b = 0; bus.cin = 0; bus.sub = 0; bus.out_ready = 1;
        bus1.in_valid = 0; bus1.a = 0; bus1.b = 0; bus1.cin = 0; bus1.sub = 0; bus1.out_ready = 1;
        bus32.in_valid = 0; bus32.a = 0; bus32.b = 0; bus32.cin = 0; bus32.sub = 0; bus32.out_ready = 1;
        repeat (2) @(posedge clk);
        #3;
        chk_reset("reset");
        rst_n = 1'b1;
        @(posedge clk); #1;

        // basic add, wrap to zero, signed overflow
        send(16'h1234, 16'h4321, 0, 0, mk(16'h5555, 0, 0, 0));
        send(16'hFFFF, 16'h0001, 0, 0, mk(16'h0000, 1, 0, 1));
        send(16'h7FFF, 16'h0001, 0, 0, mk(16'h8000, 0, 1, 0));
        // subtract: borrow, signed overflow, borrow-in
        send(16'h0005, 16'h0007, 0, 1, mk(16'hFFFE, 0, 0, 0));
        send(16'h8000, 16'h0001, 0, 1, mk(16'h7FFF, 1, 1, 0));
        send(16'h0007, 16'h0007, 1, 1, mk(16'hFFFF, 0, 0, 0));
        idle();
        drain("directed");

        // back-pressure
        lat_on = 1'b0;
        fork
            begin
                for (int i = 1; i <= 6; i++)
                    send(16'(i), 16'(i), 0, 0, mk(16'(2 * i), 0, 0, 0));
                idle();
            end
            begin
                repeat (4) @(posedge clk);
                #1 bus.out_ready = 1'b0;
                repeat (3) @(posedge clk);
                #1;
                chk("bp_out_valid", 64'(bus.out_valid), 64'h1);
                chk("bp_s",         64'(bus.s),         64'h0002);
                chk("bp_in_ready",  64'(bus.in_ready),  64'h0);
                bus.out_ready = 1'b1;
            end
        join
        drain("backpressure");
        lat_on = 1'b1;

        // full-rate random
        waits = 0;
        for (int i = 0; i < 1000; i++) begin
            logic [15:0] ra, rb;
            logic        rc, rs;
            ra = 16'($urandom); rb = 16'($urandom);
            rc = 1'($urandom); rs = 1'($urandom);
            send(ra, rb, rc, rs, model(ra, rb, rc, rs));
        end
        idle();
        chk("random_stalls", 64'(waits), 64'h0);
        drain("random");

        // reset mid-stream: one beat at the output, three in flight
        for (int i = 0; i < 4; i++) send(16'h1111, 16'h2222, 0, 0, model(16'h1111, 16'h2222, 0, 0));
        idle();
        #3 rst_n = 1'b0;
        sb.delete();
        #1 chk_reset("midreset");
        repeat (2) @(posedge clk);
        #3 rst_n = 1'b1;
        stale = 0;
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            if (bus.out_valid) stale++;
        end
        chk("midreset_stale", 64'(stale), 64'h0);
        @(posedge clk); #1;
        send(16'h0010, 16'h0020, 0, 0, mk(16'h0030, 0, 0, 0));
        idle();
        drain("after_reset");

        // CHUNK == WIDTH: single stage
        @(posedge clk); #1;
        bus1.a = 16'h1234; bus1.b = 16'h4321; bus1.cin = 0; bus1.sub = 0; bus1.in_valid = 1;
        @(posedge clk); #1;
        bus1.in_valid = 0;
        n = 0;
        while (!bus1.out_valid && n < 20) begin @(posedge clk); #1; n++; end
        chk("c16_latency", 64'(n + 1), 64'd1);
        chk("c16_s",       64'(bus1.s),    64'h5555);
        chk("c16_cout",    64'(bus1.cout), 64'h0);

        // WIDTH 32, CHUNK 8
        @(posedge clk); #1;
        bus32.a = 32'hFFFF_FFFF; bus32.b = 32'h1; bus32.cin = 0; bus32.sub = 0; bus32.in_valid = 1;
        @(posedge clk); #1;
        bus32.in_valid = 0;
        n = 0;
        while (!bus32.out_valid && n < 20) begin @(posedge clk); #1; n++; end
        chk("w32_latency", 64'(n + 1), 64'd4);
        chk("w32_s",       64'(bus32.s),    64'h0);
        chk("w32_cout",    64'(bus32.cout), 64'h1);
        chk("w32_zero",    64'(bus32.zero), 64'h1);

        repeat (3) @(posedge clk);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
